// File: rtl/cpu_bus_arbiter.sv
// Arbitrates one sram-like memory port between instruction fetch and data access.
// Define ARB_ROUND_ROBIN_EN for round-robin contention; otherwise data has fixed priority.
module cpu_bus_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_OUTS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam int unsigned PTR_W = (MAX_OUTS > 1) ? $clog2(MAX_OUTS) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(MAX_OUTS);

    // Requester IDs: 0 = inst, 1 = data.
    logic                r_lock, w_lock_nxt;
    logic                r_lock_id, w_lock_id_nxt;
    logic [MAX_OUTS-1:0] r_ids, w_ids_nxt;
    logic [PTR_W-1:0]    r_wptr, w_wptr_nxt;
    logic [PTR_W-1:0]    r_rptr, w_rptr_nxt;
    logic [PTR_W:0]      r_count, w_count_nxt;

    logic w_lock_hold;
    logic w_contend_sel;
    logic w_sel;
    logic w_sel_req;
    logic w_full;
    logic w_accept;
    logic w_pop;
    logic w_head;

`ifdef ARB_ROUND_ROBIN_EN
    // Preferred requester on contention: the one not granted at the last accept.
    logic r_rr, w_rr_nxt;

    always_comb begin
        w_rr_nxt = r_rr;
        if (w_accept) begin
            w_rr_nxt = ~w_sel;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr <= 1'b1;
        end else begin
            r_rr <= w_rr_nxt;
        end
    end

    assign w_contend_sel = r_rr;
`else
    assign w_contend_sel = 1'b1;
`endif

    always_comb begin
        // A lock whose owner dropped req is released rather than honoured.
        w_lock_hold = r_lock && (r_lock_id ? data_req : inst_req);
        if (w_lock_hold) begin
            w_sel = r_lock_id;
        end else if (inst_req && data_req) begin
            w_sel = w_contend_sel;
        end else begin
            w_sel = data_req;
        end
        w_sel_req = w_sel ? data_req : inst_req;
        w_full    = (r_count == FULL_CNT);

        bus_req   = w_sel_req && !w_full && !reset;
        bus_wr    = w_sel ? data_wr    : inst_wr;
        bus_size  = w_sel ? data_size  : inst_size;
        bus_addr  = w_sel ? data_addr  : inst_addr;
        bus_wdata = w_sel ? data_wdata : inst_wdata;

        w_accept     = bus_req && bus_addr_ok;
        inst_addr_ok = w_accept && !w_sel;
        data_addr_ok = w_accept && w_sel;

        w_head       = r_ids[r_rptr];
        w_pop        = bus_data_ok && (r_count != '0) && !reset;
        inst_data_ok = w_pop && !w_head;
        data_data_ok = w_pop && w_head;
        inst_rdata   = bus_rdata;
        data_rdata   = bus_rdata;
    end

    always_comb begin
        w_lock_nxt    = bus_req && !bus_addr_ok;
        w_lock_id_nxt = w_sel;
        w_ids_nxt     = r_ids;
        w_wptr_nxt    = r_wptr;
        w_rptr_nxt    = r_rptr;
        w_count_nxt   = r_count;
        if (w_accept) begin
            w_ids_nxt[r_wptr] = w_sel;
            w_wptr_nxt        = r_wptr + PTR_W'(1);
        end
        if (w_pop) begin
            w_rptr_nxt = r_rptr + PTR_W'(1);
        end
        case ({w_accept, w_pop})
            2'b10:   w_count_nxt = r_count + (PTR_W + 1)'(1);
            2'b01:   w_count_nxt = r_count - (PTR_W + 1)'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lock    <= 1'b0;
            r_lock_id <= 1'b0;
            r_ids     <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
        end else begin
            r_lock    <= w_lock_nxt;
            r_lock_id <= w_lock_id_nxt;
            r_ids     <= w_ids_nxt;
            r_wptr    <= w_wptr_nxt;
            r_rptr    <= w_rptr_nxt;
            r_count   <= w_count_nxt;
        end
    end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed and randomized bench for cpu_bus_arbiter against a queue-based reference model.
module tb_cpu_bus_arbiter;

    localparam int MAX_OUTS = 4;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        inst_req = 0, inst_wr = 0, data_req = 0, data_wr = 0;
    logic [1:0]  inst_size = 0, data_size = 0;
    logic [31:0] inst_addr = 0, inst_wdata = 0, data_addr = 0, data_wdata = 0;
    logic        bus_addr_ok = 0, bus_data_ok = 0;
    logic [31:0] bus_rdata = 0;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr, bus_wdata;

    always #5 clk = ~clk;

    cpu_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUTS(MAX_OUTS)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: owners of accepted-but-unanswered requests, in order.
    int q_own[$];
    bit m_held = 0;
    int m_held_id = 0;
    int m_rr = 1;
    bit e_bus_req, e_accept, e_pop;
    int e_sel;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait for combinational settle, then compare every output to the model.
    task automatic eval();
        bit ir, dr, sreq;
        int head;
        #3;
        ir = inst_req;
        dr = data_req;
        if (m_held && (m_held_id == 1 ? dr : ir)) e_sel = m_held_id;
        else if (ir && dr) e_sel = RR ? m_rr : 1;
        else e_sel = dr ? 1 : 0;
        sreq = (e_sel == 1) ? dr : ir;
        e_bus_req = sreq && (q_own.size() < MAX_OUTS) && !reset;
        e_accept = e_bus_req && bus_addr_ok;
        e_pop = bus_data_ok && (q_own.size() > 0) && !reset;
        head = (q_own.size() > 0) ? q_own[0] : -1;
        chk("bus_req", bus_req, e_bus_req);
        chk("inst_addr_ok", inst_addr_ok, e_accept && e_sel == 0);
        chk("data_addr_ok", data_addr_ok, e_accept && e_sel == 1);
        chk("inst_data_ok", inst_data_ok, e_pop && head == 0);
        chk("data_data_ok", data_data_ok, e_pop && head == 1);
        chk("inst_rdata", inst_rdata, bus_rdata);
        chk("data_rdata", data_rdata, bus_rdata);
        if (e_bus_req) begin
            chk("bus_addr", bus_addr, (e_sel == 1) ? data_addr : inst_addr);
            chk("bus_wr", bus_wr, (e_sel == 1) ? data_wr : inst_wr);
            chk("bus_size", bus_size, (e_sel == 1) ? data_size : inst_size);
            chk("bus_wdata", bus_wdata, (e_sel == 1) ? data_wdata : inst_wdata);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            q_own.delete();
            m_held = 0;
            m_rr = 1;
        end else begin
            if (e_pop) void'(q_own.pop_front());
            if (e_accept) begin
                q_own.push_back(e_sel);
                m_rr = 1 - e_sel;
            end
            m_held = e_bus_req && !bus_addr_ok;
            m_held_id = e_sel;
        end
        #1;
    endtask

    task automatic drain(input int n);
        bus_addr_ok = 0;
        bus_data_ok = 1;
        for (int i = 0; i < n; i++) begin
            bus_rdata = $urandom;
            eval();
            tick();
        end
        bus_data_ok = 0;
    endtask

    task automatic rnd_inputs();
        if (!(inst_req && !(e_accept && e_sel == 0))) begin
            inst_req = 1'($urandom_range(0, 1));
            inst_wr = 1'($urandom_range(0, 1));
            inst_size = 2'($urandom_range(0, 2));
            inst_addr = $urandom;
            inst_wdata = $urandom;
        end
        if (!(data_req && !(e_accept && e_sel == 1))) begin
            data_req = 1'($urandom_range(0, 1));
            data_wr = 1'($urandom_range(0, 1));
            data_size = 2'($urandom_range(0, 2));
            data_addr = $urandom;
            data_wdata = $urandom;
        end
        bus_addr_ok = ($urandom_range(0, 9) < 6);
        bus_data_ok = ($urandom_range(0, 9) < 4);
        bus_rdata = $urandom;
        reset = ($urandom_range(0, 199) == 0);
    endtask

    initial begin
        #1 reset = 1;
        eval();
        chk("rst_bus_req", bus_req, 0);
        tick();
        reset = 0;

        // Single inst read with a response two cycles later.
        inst_req = 1; inst_addr = 32'h1000; inst_size = 2; bus_addr_ok = 1;
        eval();
        chk("t1_inst_aok", inst_addr_ok, 1);
        chk("t1_bus_addr", bus_addr, 32'h1000);
        tick();
        inst_req = 0; bus_addr_ok = 0;
        eval();
        tick();
        bus_data_ok = 1; bus_rdata = 32'h1234_5678;
        eval();
        chk("t1_inst_dok", inst_data_ok, 1);
        chk("t1_inst_rdata", inst_rdata, 32'h1234_5678);
        chk("t1_data_dok", data_data_ok, 0);
        tick();
        bus_data_ok = 0;

        // Contention: data first after reset, then inst.
        inst_req = 1; inst_addr = 32'h2000;
        data_req = 1; data_addr = 32'h3000; data_wr = 1; data_wdata = 32'hCAFE_0001;
        bus_addr_ok = 1;
        eval();
        chk("t2_data_aok", data_addr_ok, 1);
        chk("t2_inst_aok0", inst_addr_ok, 0);
        tick();
        data_req = 0;
        eval();
        chk("t2_inst_aok", inst_addr_ok, 1);
        tick();
        inst_req = 0;
        drain(2);
        // Second contention right after a data accept: round-robin favours inst.
        inst_req = 1; data_req = 1; data_addr = 32'h3004; bus_addr_ok = 1;
        eval();
        chk("t2b_data_aok", data_addr_ok, 1);
        tick();
        data_addr = 32'h3008;
        eval();
        chk("t2b_inst_aok", inst_addr_ok, RR);
        chk("t2b_data_aok2", data_addr_ok, !RR);
        tick();
        inst_req = !RR; data_req = RR;
        eval();
        chk("t2b_rest_aok", inst_addr_ok | data_addr_ok, 1);
        tick();
        inst_req = 0; data_req = 0;
        drain(3);

        // Lock: inst held against a later data request.
        inst_req = 1; inst_addr = 32'h4000; bus_addr_ok = 0;
        eval();
        chk("t3_addr0", bus_addr, 32'h4000);
        tick();
        data_req = 1; data_addr = 32'h5000;
        for (int i = 0; i < 2; i++) begin
            eval();
            chk("t3_addr_held", bus_addr, 32'h4000);
            tick();
        end
        bus_addr_ok = 1;
        eval();
        chk("t3_inst_aok", inst_addr_ok, 1);
        chk("t3_addr3", bus_addr, 32'h4000);
        tick();
        inst_req = 0;
        eval();
        chk("t3_data_aok", data_addr_ok, 1);
        tick();
        data_req = 0;
        drain(2);

        // Fill to MAX_OUTS, stall, then drain in order.
        bus_addr_ok = 1;
        for (int i = 0; i < 4; i++) begin
            data_req = (i % 2 == 0); inst_req = (i % 2 == 1);
            data_addr = 32'h6000 + i; inst_addr = 32'h7000 + i;
            eval();
            tick();
        end
        data_req = 1; inst_req = 0; data_addr = 32'h6100;
        eval();
        chk("t4_full_req", bus_req, 0);
        tick();
        bus_addr_ok = 0; bus_data_ok = 1;
        for (int i = 0; i < 4; i++) begin
            eval();
            chk("t4_data_dok", data_data_ok, (i % 2 == 0));
            chk("t4_inst_dok", inst_data_ok, (i % 2 == 1));
            if (i == 0) chk("t4_nobypass", bus_req, 0);
            tick();
        end
        bus_data_ok = 0; bus_addr_ok = 1;
        eval();
        chk("t4_req_again", bus_req, 1);
        chk("t4_data_aok", data_addr_ok, 1);
        tick();

        // Push and pop in one cycle at count 2.
        data_req = 0; inst_req = 1; inst_addr = 32'h8000;
        eval();
        tick();
        inst_req = 0; data_req = 1; data_addr = 32'h8100; bus_data_ok = 1;
        eval();
        chk("t5_pop_data", data_data_ok, 1);
        chk("t5_push_data", data_addr_ok, 1);
        tick();
        data_req = 0; bus_addr_ok = 0;
        eval();
        chk("t5_pop_inst", inst_data_ok, 1);
        tick();
        eval();
        chk("t5_pop_data2", data_data_ok, 1);
        tick();
        eval();
        chk("t5_empty_d", data_data_ok, 0);
        chk("t5_empty_i", inst_data_ok, 0);
        tick();
        bus_data_ok = 0;

        // Reset with three outstanding.
        bus_addr_ok = 1;
        for (int i = 0; i < 3; i++) begin
            data_req = (i != 1); inst_req = (i == 1);
            eval();
            tick();
        end
        data_req = 0; inst_req = 0; bus_addr_ok = 0; reset = 1;
        eval();
        tick();
        reset = 0; bus_data_ok = 1;
        eval();
        chk("t6_no_dok_d", data_data_ok, 0);
        chk("t6_no_dok_i", inst_data_ok, 0);
        tick();
        bus_data_ok = 0; inst_req = 1; inst_addr = 32'h9000; bus_addr_ok = 1;
        eval();
        chk("t6_inst_aok", inst_addr_ok, 1);
        tick();
        inst_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
        eval();
        chk("t6_inst_dok", inst_data_ok, 1);
        tick();
        bus_data_ok = 0;

        // Randomized traffic; requesters hold req until their addr_ok.
        for (int c = 0; c < 3000; c++) begin
            rnd_inputs();
            eval();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_bus_arbiter.md
# cpu_bus_arbiter

Shares the CPU's single sram-like memory port between the instruction-fetch requester (IF stage) and the data requester (EXE stage issuing loads and stores, with MEM stage consuming read data). Each cycle it picks one requester, forwards its request to the shared bus, and records which requester was accepted in an in-order outstanding-ID FIFO. It then steers each returning `data_ok`/`rdata` back to the owning requester. The block adds no latency on either the address or the data path.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MAX_OUTS`, 4, maximum outstanding accepted-but-unanswered requests; power of two, 2..16

Ports:
- `clk`  in  1  clock; all state updates on its rising edge
- `reset`  in  1  asynchronous, active-high reset
- `inst_req` / `data_req`  in  1  request valid; held stable until the matching `*_addr_ok`
- `inst_wr` / `data_wr`  in  1  1 = write
- `inst_size` / `data_size`  in  2  0 = byte, 1 = half, 2 = word
- `inst_addr` / `data_addr`  in  ADDR_W  byte address
- `inst_wdata` / `data_wdata`  in  DATA_W  write data
- `inst_addr_ok` / `data_addr_ok`  out  1  request accepted this cycle
- `inst_data_ok` / `data_data_ok`  out  1  response for this requester this cycle
- `inst_rdata` / `data_rdata`  out  DATA_W  read data; equals `bus_rdata`
- `bus_req`, `bus_wr`, `bus_size`, `bus_addr`, `bus_wdata`  out  1/1/2/ADDR_W/DATA_W  shared-port request
- `bus_addr_ok`, `bus_data_ok`  in  1  shared-port handshakes
- `bus_rdata`  in  DATA_W  shared-port read data

## Operation
- Grant selection when unlocked:
  - Only one requester active: that requester is selected.
  - Both active: `data` wins (default; see Configuration).
- `bus_req` = selected requester's req AND `count < MAX_OUTS` AND NOT `reset`. `bus_wr`, `bus_size`, `bus_addr` and `bus_wdata` mux from the selected requester. They are don't-care when `bus_req`=0.
- Lock:
  - If `bus_req`=1 and `bus_addr_ok`=0, the grant is registered and held on later cycles, even if the other requester asserts.
  - The lock clears on the cycle `bus_addr_ok`=1.
  - A locked requester that drops req is a protocol violation. The lock is nevertheless released when its req is 0.
- Accept: `bus_req && bus_addr_ok`.
  - Asserts `*_addr_ok` of the granted requester only.
  - Pushes the granted ID (0 = inst, 1 = data) into the FIFO.
- Response: on `bus_data_ok` with `count > 0`:
  - Pop the head ID.
  - Assert `inst_data_ok` or `data_data_ok` for that ID.
- `bus_data_ok` with `count == 0` is ignored: no `*_data_ok` is asserted and no state changes.
- Push and pop in the same cycle: `count` is unchanged and both pointers advance.
- Full (`count == MAX_OUTS`): `bus_req` is 0 even if a pop occurs in the same cycle. No bypass.
- Pointers are `log2(MAX_OUTS)` bits and wrap modulo MAX_OUTS. `count` is `log2(MAX_OUTS)+1` bits.

## Timing
- Address path: combinational. `*_addr_ok` follows `bus_addr_ok` in the same cycle.
- Data path: combinational. `*_data_ok` and `*_rdata` follow `bus_data_ok`/`bus_rdata` in the same cycle.
- Added latency: 0 cycles.
- Reset:
  - Clears `count`, the pointers, the lock and the round-robin pointer (rr pointer = data first).
  - While `reset` is high, `bus_req` and all `*_addr_ok` / `*_data_ok` outputs are 0.
- Reset mid-operation: all outstanding IDs are discarded. Bus responses arriving after reset hit an empty FIFO and are dropped.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - On contention the requester not granted at the most recent accept wins.
  - The rr pointer updates only on accept.
- Undefined: fixed priority, `data` over `inst`.
- Lock, FIFO and response routing are identical in both builds.

## Test plan
- Single inst read, `bus_addr_ok`=1 at cycle 0, `bus_data_ok`=1 at cycle 2 with rdata `0x1234_5678` -> `inst_addr_ok`=1 at cycle 0; `inst_data_ok`=1 and `inst_rdata`=`0x1234_5678` at cycle 2; `data_*_ok` stay 0.
- Both req at cycle 0 with `bus_addr_ok`=1 -> data accepted at cycle 0 and inst at cycle 1 (fixed priority). With `ARB_ROUND_ROBIN_EN`, after a data accept the next contended accept goes to inst.
- inst req at cycle 0 with `bus_addr_ok`=0 for 3 cycles, data req from cycle 1 -> `bus_addr` stays `inst_addr` through cycle 3; inst is accepted at cycle 3 and data at cycle 4.
- Accept data, inst, data, inst with no responses (MAX_OUTS=4), then a 5th req -> `bus_req`=0. Four `bus_data_ok` pulses then produce `data_data_ok`, `inst_data_ok`, `data_data_ok`, `inst_data_ok` in order, after which `bus_req` re-asserts.
- Count=2, then `bus_data_ok` and a new accept in the same cycle -> count stays 2; the head pops to the correct owner.
- Count=3, assert `reset` for 1 cycle, then `bus_data_ok` -> no `*_data_ok`; `count`=0; a new request is accepted normally.
